// File: rtl/maxpool_fp16_stream.sv
// Streaming FP16 max-pool: reduces each POOL_SIZE-element window to its max.
// Optional MAXPOOL_ARGMAX_EN adds out_idx, the winning element's position.
module maxpool_fp16_stream #(
  parameter int POOL_SIZE = 4,
  localparam int CW = $clog2(POOL_SIZE)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
`ifdef MAXPOOL_ARGMAX_EN
  ,
  output logic [CW-1:0] out_idx
`endif
);

  function automatic logic is_nan(input logic [15:0] x);
    return (&x[14:10]) && (|x[9:0]);
  endfunction

  // Sign-magnitude ordering; +0 and -0 are equal.
  function automatic logic fp_gt(input logic [15:0] a,
                                 input logic [15:0] b);
    logic res;
    if (a[14:0] == 15'd0 && b[14:0] == 15'd0)
      res = 1'b0;
    else if (a[15] != b[15])
      res = !a[15];
    else if (!a[15])
      res = a[14:0] > b[14:0];
    else
      res = a[14:0] < b[14:0];
    return res;
  endfunction

  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   max_q, max_d;
  logic [15:0]   out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          accept, consume, last, repl;

`ifdef MAXPOOL_ARGMAX_EN
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] out_idx_q, out_idx_d;
`endif

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign consume   = out_valid_q && out_ready;
  assign last      = cnt_q == CW'(POOL_SIZE - 1);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

  always_comb begin
    repl = 1'b0;
    if (cnt_q == '0)
      repl = 1'b1;
    else if (is_nan(max_q))
      repl = !is_nan(in_data);
    else if (!is_nan(in_data))
      repl = fp_gt(in_data, max_q);
  end

  always_comb begin
    cnt_d       = cnt_q;
    max_d       = max_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
`ifdef MAXPOOL_ARGMAX_EN
    idx_d       = idx_q;
    out_idx_d   = out_idx_q;
`endif
    if (consume)
      out_valid_d = 1'b0;
    if (accept) begin
      if (repl) begin
        max_d = in_data;
`ifdef MAXPOOL_ARGMAX_EN
        idx_d = cnt_q;
`endif
      end
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        out_valid_d = 1'b1;
        out_data_d  = is_nan(max_d) ? 16'h7E00 : max_d;
`ifdef MAXPOOL_ARGMAX_EN
        out_idx_d   = is_nan(max_d) ? '0 : idx_d;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      max_q       <= 16'h0000;
      out_data_q  <= 16'h0000;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef MAXPOOL_ARGMAX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      out_idx_q <= '0;
    end else begin
      idx_q     <= idx_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_idx = out_idx_q;
`endif

endmodule
